hourclock_set_ctrl: RTL
=======================

Name: hourclock_set_ctrl

Overview:
Controller that sequences the 12-hour hourclock datapath. It generates the clock's advance-enable from a programmable prescaler and runs a time-set state machine driven by mode/increment button pulses. While editing it freezes the clock, edits BCD hour/min/sec/pm shadow values, and commits them with a one-cycle load strobe. It sits between the button debouncers and the hourclock instance.

Parameters:
TICK_DIV, 10, clk cycles per clk_ena pulse in RUN; legal range >= 1; TICK_DIV=1 gives a continuous clk_ena.
CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-low reset.
run_en  in  1  global run enable; 0 freezes the prescaler.
btn_mode  in  1  single-cycle pulse; advances the set FSM.
btn_inc  in  1  single-cycle pulse; increments the field being edited.
cur_pm  in  1  current pm flag from hourclock.
cur_hour  in  8  current hour, BCD.
cur_min  in  8  current minute, BCD.
cur_sec  in  8  current second, BCD.
clk_ena  out  1  advance enable to hourclock ena.
load  out  1  one-cycle commit strobe to the hourclock load port.
set_pm  out  1  value to load.
set_hour  out  8  BCD value to load.
set_min  out  8  BCD value to load.
set_sec  out  8  BCD value to load.
mode_o  out  3  state encoding: RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3, COMMIT=4.
editing  out  1  high in SET_HR, SET_MIN and SET_SEC.

Behaviour:
- Reset (reset=0, async) puts outputs and state at: RUN, prescaler cnt=0, clk_ena=0, set_hour=8'h12, set_min=8'h00, set_sec=8'h00, set_pm=0. Reset mid-edit discards edits and issues no load.
- RUN with run_en=1, each edge: if cnt==TICK_DIV-1 then cnt<=0 and clk_ena<=1, else cnt<=cnt+1 and clk_ena<=0.
  - clk_ena is registered, high exactly 1 cycle in every TICK_DIV.
  - The first pulse occurs on the TICK_DIV-th edge after entering RUN.
- RUN with run_en=0: cnt holds and clk_ena<=0.
- RUN + btn_mode: capture cur_* into set_*, go to SET_HR, cnt<=0, clk_ena<=0. btn_inc is ignored in RUN.
- SET_HR + btn_inc: hour BCD counts 01..12, then 12 wraps to 01. The 11->12 step toggles set_pm. A captured invalid hour (0, >12, or a nibble >9) increments to 01 with set_pm unchanged.
- SET_HR + btn_mode: go to SET_MIN.
- SET_MIN + btn_inc: counts 00..59, then 59 wraps to 00. No carry into hour. An invalid value increments to 00.
- SET_MIN + btn_mode: go to SET_SEC.
- SET_SEC + btn_inc: same rules as SET_MIN. btn_mode: go to COMMIT.
- COMMIT: lasts exactly 1 cycle, then unconditionally returns to RUN with cnt=0. Both buttons are ignored.
- load is decoded from the state register: high only while in COMMIT. set_* are stable throughout COMMIT and hold their values afterwards.
- clk_ena=0 in every state other than RUN.
- btn_mode and btn_inc in the same cycle: mode wins and the increment is dropped.
- run_en does not affect the set FSM. Editing is possible with run_en=0.
- BCD rules: low-nibble carry at 9; all arithmetic is on BCD nibbles, never binary.

Test Plan:
1. Reset release, run_en=1, TICK_DIV=10 -> clk_ena pulses at edges 10, 20, 30, each 1 cycle wide; mode_o=0, load=0.
2. run_en=0 for 25 cycles at cnt=4 -> no clk_ena. After re-enable, the next pulse arrives exactly 6 edges later.
3. cur_* = 11:59:58 AM. Sequence: mode; inc; mode; inc; mode; inc×3; mode -> set_hour=12, set_pm=1, set_min=00, set_sec=01. load high 1 cycle, one edge after the final mode pulse. mode_o returns to 0. clk_ena stays 0 throughout editing.
4. In SET_HR from 12: inc -> 01, pm unchanged. In SET_MIN from 8'h59: inc -> 8'h00, hour unchanged.
5. btn_mode and btn_inc asserted together in SET_MIN with min=8'h07 -> state becomes SET_SEC, min remains 8'h07.
6. reset asserted in SET_SEC -> immediately (async) mode_o=0, set_hour=8'h12, no load pulse ever emitted. First clk_ena arrives TICK_DIV edges after release.

Source files
------------

// File: rtl/hourclock_set_if.sv
`default_nettype none
// ============================================================================
// Module   : hourclock_set_if
// Brief    : Button, current-time and load-value bundle between the set
//            controller and its surroundings.
// Revision : 1.0
// ============================================================================
interface hourclock_set_if;
    logic       run_en;
    logic       btn_mode;
    logic       btn_inc;
    logic       cur_pm;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       clk_ena;
    logic       load;
    logic       set_pm;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic [7:0] set_sec;
    logic [2:0] mode_o;
    logic       editing;

    modport master (
        output run_en, btn_mode, btn_inc, cur_pm, cur_hour, cur_min, cur_sec,
        input  clk_ena, load, set_pm, set_hour, set_min, set_sec, mode_o, editing
    );

    modport slave (
        input  run_en, btn_mode, btn_inc, cur_pm, cur_hour, cur_min, cur_sec,
        output clk_ena, load, set_pm, set_hour, set_min, set_sec, mode_o, editing
    );
endinterface
`default_nettype wire

// File: rtl/hourclock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hourclock_set_ctrl
// Brief    : Prescaled advance-enable plus button-driven BCD time-set FSM
//            that freezes, edits and commits the hourclock time.
// Revision : 1.0
// ============================================================================
module hourclock_set_ctrl #(
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 16
) (
    input wire             clk,
    input wire             reset,
    hourclock_set_if.slave bus
);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_SET_HR  = 3'd1;
    localparam logic [2:0] S_SET_MIN = 3'd2;
    localparam logic [2:0] S_SET_SEC = 3'd3;
    localparam logic [2:0] S_COMMIT  = 3'd4;

    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_ena;
    logic             r_set_pm;
    logic [7:0]       r_set_hour;
    logic [7:0]       r_set_min;
    logic [7:0]       r_set_sec;
    logic             w_load;
    logic             w_editing;
    logic             w_inc;

    // Mode has priority: an increment arriving with mode is dropped.
    assign w_inc = bus.btn_inc & ~bus.btn_mode;

    // Returns {pm, hour}. Hours run 01..12; only 11->12 flips pm.
    function automatic logic [8:0] f_hour_inc(input logic [7:0] h, input logic pm);
        logic valid;
        valid = (h != 8'h00) && (h <= 8'h12) && (h[3:0] <= 4'd9);
        if (!valid || h == 8'h12)
            f_hour_inc = {pm, 8'h01};
        else if (h == 8'h11)
            f_hour_inc = {~pm, 8'h12};
        else if (h[3:0] == 4'd9)
            f_hour_inc = {pm, h[7:4] + 4'd1, 4'd0};
        else
            f_hour_inc = {pm, h[7:4], h[3:0] + 4'd1};
    endfunction

    // Minutes/seconds run 00..59; anything outside BCD 00..59 restarts at 00.
    function automatic logic [7:0] f_ms_inc(input logic [7:0] v);
        logic valid;
        valid = (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
        if (!valid || v == 8'h59)
            f_ms_inc = 8'h00;
        else if (v[3:0] == 4'd9)
            f_ms_inc = {v[7:4] + 4'd1, 4'd0};
        else
            f_ms_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:     if (bus.btn_mode) w_state_nxt = S_SET_HR;
            S_SET_HR:  if (bus.btn_mode) w_state_nxt = S_SET_MIN;
            S_SET_MIN: if (bus.btn_mode) w_state_nxt = S_SET_SEC;
            S_SET_SEC: if (bus.btn_mode) w_state_nxt = S_COMMIT;
            S_COMMIT:  w_state_nxt = S_RUN;
            default:   w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_editing = 1'b0;
        case (r_state)
            S_SET_HR, S_SET_MIN, S_SET_SEC: w_editing = 1'b1;
            S_COMMIT:                       w_load    = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------ prescaler
    // Counter is parked at zero outside RUN so every return to RUN yields a
    // full TICK_DIV interval before the first enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_clk_ena <= 1'b0;
        end else begin
            r_clk_ena <= 1'b0;
            if (r_state != S_RUN || bus.btn_mode) begin
                r_cnt <= '0;
            end else if (bus.run_en) begin
                if (r_cnt == c_TICK_LAST) begin
                    r_cnt     <= '0;
                    r_clk_ena <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------- shadow values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_set_pm   <= 1'b0;
            r_set_hour <= 8'h12;
            r_set_min  <= 8'h00;
            r_set_sec  <= 8'h00;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.btn_mode) begin
                        r_set_pm   <= bus.cur_pm;
                        r_set_hour <= bus.cur_hour;
                        r_set_min  <= bus.cur_min;
                        r_set_sec  <= bus.cur_sec;
                    end
                end
                S_SET_HR: begin
                    if (w_inc)
                        {r_set_pm, r_set_hour} <= f_hour_inc(r_set_hour, r_set_pm);
                end
                S_SET_MIN: begin
                    if (w_inc)
                        r_set_min <= f_ms_inc(r_set_min);
                end
                S_SET_SEC: begin
                    if (w_inc)
                        r_set_sec <= f_ms_inc(r_set_sec);
                end
                default: ;
            endcase
        end
    end

    assign bus.clk_ena  = r_clk_ena;
    assign bus.load     = w_load;
    assign bus.set_pm   = r_set_pm;
    assign bus.set_hour = r_set_hour;
    assign bus.set_min  = r_set_min;
    assign bus.set_sec  = r_set_sec;
    assign bus.mode_o   = r_state;
    assign bus.editing  = w_editing;

endmodule
`default_nettype wire
